// File: rtl/config_shift_sequencer_pkg.sv
// Shared fabric configuration package: default geometry and sequencer state encoding.
// Imported by the config shift sequencer and its word shifter.
package config_shift_sequencer_pkg;

  localparam int DEF_NUM_COLS   = 4;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_CHAIN_BITS = 1024;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_SET   = 2'd3;

  // Index width for a one-hot vector of n entries; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_word_shifter.sv
// One config word held in a right-shifting register, with a count of bits still
// to be shifted out so the sequencer knows when the word is exhausted.
module cfg_word_shifter
  import config_shift_sequencer_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic              shift,
  output logic              bit_out,
  output logic              last_bit
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;

  // NOTE: the register file is small and feeds the data output, so it is fully
  // reset rather than left unknown; reset clears both data and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      // A load in the same cycle as the final shift replaces the word outright.
      sr  <= data;
      cnt <= CNT_W'(WORD_W);
    end else if (shift) begin
      sr  <= sr >> 1;
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign bit_out  = sr[0];
  assign last_bit = (cnt == CNT_W'(1));

endmodule

// File: rtl/config_shift_sequencer.sv
// Streams config words LSB-first into one selected fabric column chain, then
// pulses that column's set strobe. FSM and the total-bit counter live here.
module config_shift_sequencer
  import config_shift_sequencer_pkg::*;
#(
  parameter  int NUM_COLS   = DEF_NUM_COLS,
  parameter  int WORD_W     = DEF_WORD_W,
  parameter  int CHAIN_BITS = DEF_CHAIN_BITS,
  localparam int COL_W      = idx_width(NUM_COLS),
  localparam int NB_W       = $clog2(CHAIN_BITS) + 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic [COL_W-1:0]    col_i,
  input  logic [NB_W-1:0]     nbits_i,
  input  logic                word_valid_i,
  input  logic [WORD_W-1:0]   word_data_i,
  output logic                word_ready_o,
  input  logic                abort_i,
  output logic                cfg_bit_o,
  output logic [NUM_COLS-1:0] shift_o,
  output logic [NUM_COLS-1:0] set_o,
  output logic                cen_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [COL_W-1:0] col_q;
  logic [NB_W-1:0]  total_q;
  logic             err_q;

  logic req_ok;
  logic accept;
  logic handshake;
  logic total_last;
  logic word_last;
  logic sh_bit;
  logic sh_shift;
  logic sh_clear;
  logic active;

  assign req_ok = (int'(col_i) < NUM_COLS) && (nbits_i != '0) &&
                  (int'(nbits_i) <= CHAIN_BITS);
  assign accept = (state == ST_IDLE) && start_i && req_ok;
  assign active = (state == ST_LOAD) || (state == ST_SHIFT);

  // In SHIFT the total is at least one, so "not last" means more than one remains.
  assign total_last   = (total_q == NB_W'(1));
  assign word_ready_o = (state == ST_LOAD) ||
                        ((state == ST_SHIFT) && word_last && !total_last);
  assign handshake    = word_valid_i && word_ready_o && !abort_i;

  assign sh_shift = (state == ST_SHIFT) && !abort_i;
  assign sh_clear = (state == ST_SET) || (active && abort_i);

  cfg_word_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .clear    (sh_clear),
    .load     (handshake),
    .data     (word_data_i),
    .shift    (sh_shift),
    .bit_out  (sh_bit),
    .last_bit (word_last)
  );

  // NOTE: every variable assigned in a combinational block gets a default first,
  // so no path through the case statement can leave it holding a stale value.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (abort_i)        state_nxt = ST_IDLE;
        else if (handshake) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort_i)                      state_nxt = ST_IDLE;
        else if (total_last)              state_nxt = ST_SET;
        else if (word_last && !handshake) state_nxt = ST_LOAD;
      end
      ST_SET:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state   <= ST_IDLE;
      col_q   <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= (state == ST_IDLE) && start_i && !req_ok;
      if (accept) begin
        col_q   <= col_i;
        total_q <= nbits_i;
      end else if (sh_shift) begin
        total_q <= total_q - NB_W'(1);
      end
    end
  end

  always_comb begin
    shift_o = '0;
    set_o   = '0;
    if (state == ST_SHIFT) shift_o[col_q] = 1'b1;
    if (state == ST_SET)   set_o[col_q]   = 1'b1;
  end

  assign cfg_bit_o = (state == ST_SHIFT) && sh_bit;
  assign busy_o    = (state != ST_IDLE);
  assign cen_o     = (state != ST_IDLE);
  assign done_o    = (state == ST_SET);
  assign err_o     = err_q;

endmodule

// File: tb/tb_config_shift_sequencer.sv
// Self-checking bench: the expected serial stream is the concatenation of the
// supplied words, truncated to nbits, compared bit by bit against cfg_bit_o.
module tb_config_shift_sequencer;

  localparam int NUM_COLS   = 4;
  localparam int WORD_W     = 32;
  localparam int CHAIN_BITS = 1024;
  localparam int COL_W      = 2;
  localparam int NB_W       = 11;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i;
  logic                start_i;
  logic [COL_W-1:0]    col_i;
  logic [NB_W-1:0]     nbits_i;
  logic                word_valid_i;
  logic [WORD_W-1:0]   word_data_i;
  logic                word_ready_o;
  logic                abort_i;
  logic                cfg_bit_o;
  logic [NUM_COLS-1:0] shift_o;
  logic [NUM_COLS-1:0] set_o;
  logic                cen_o, busy_o, done_o, err_o;

  // Three-column instance, used only to exercise the out-of-range column check.
  logic       start3, abort3;
  logic [1:0] col3;
  logic       ready3, bit3, cen3, busy3, done3, err3;
  logic [2:0] shift3, set3;

  int vectors = 0;
  int errors  = 0;
  logic [WORD_W-1:0] words[$];

  always #5 wb_clk_i = ~wb_clk_i;

  config_shift_sequencer #(
    .NUM_COLS(NUM_COLS), .WORD_W(WORD_W), .CHAIN_BITS(CHAIN_BITS)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .col_i(col_i),
    .nbits_i(nbits_i), .word_valid_i(word_valid_i), .word_data_i(word_data_i),
    .word_ready_o(word_ready_o), .abort_i(abort_i), .cfg_bit_o(cfg_bit_o),
    .shift_o(shift_o), .set_o(set_o), .cen_o(cen_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  config_shift_sequencer #(
    .NUM_COLS(3), .WORD_W(WORD_W), .CHAIN_BITS(CHAIN_BITS)
  ) dut3 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start3), .col_i(col3),
    .nbits_i(nbits_i), .word_valid_i(1'b0), .word_data_i(word_data_i),
    .word_ready_o(ready3), .abort_i(abort3), .cfg_bit_o(bit3),
    .shift_o(shift3), .set_o(set3), .cen_o(cen3), .busy_o(busy3),
    .done_o(done3), .err_o(err3)
  );

  // Runs one load of nbits into column col from the words queue. gap inserts
  // that many idle-valid cycles before the second word; abort_at >= 0 aborts
  // while bit index abort_at is on the wire; junk issues ignored starts.
  task automatic run_load(input int col, input int nbits, input int gap,
                          input int abort_at, input bit junk, input string name);
    int nwords, idx, nshift, nset, ndone, stalls, first_shift, gap_left;
    int errs_seen, bad_ready, exp_shift, exp_set, exp_stall;
    bit finished, aborted;
    logic [WORD_W-1:0]   w;
    logic [NUM_COLS-1:0] exp_oh;
    nwords = (nbits + WORD_W - 1) / WORD_W;
    idx = 0; nshift = 0; nset = 0; ndone = 0; stalls = 0; first_shift = -1;
    gap_left = gap; errs_seen = 0; bad_ready = 0; finished = 0; aborted = 0;
    exp_oh = '0;
    exp_oh[col] = 1'b1;

    @(negedge wb_clk_i);
    start_i = 1'b1; col_i = COL_W'(col); nbits_i = NB_W'(nbits);
    word_valid_i = 1'b1; word_data_i = words[0]; abort_i = 1'b0;

    for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      @(negedge wb_clk_i);
      if (err_o) errs_seen++;
      if (shift_o !== '0) begin
        if (first_shift < 0) first_shift = cyc;
        vectors++;
        if (shift_o !== exp_oh) begin
          errors++;
          $display("FAIL %s shift_o: got %b want %b (bit %0d)", name, shift_o, exp_oh, nshift);
        end
        w = words[nshift / WORD_W];
        vectors++;
        if (cfg_bit_o !== w[nshift % WORD_W]) begin
          errors++;
          $display("FAIL %s cfg_bit: bit %0d got %b want %b", name, nshift, cfg_bit_o, w[nshift % WORD_W]);
        end
        nshift++;
      end else if (busy_o && first_shift >= 0 && set_o === '0) begin
        stalls++;
      end
      if (set_o !== '0) begin
        nset++;
        vectors++;
        if (set_o !== exp_oh || done_o !== 1'b1) begin
          errors++;
          $display("FAIL %s set_o: got %b done=%b want %b done=1", name, set_o, done_o, exp_oh);
        end
      end
      if (done_o) ndone++;
      if (!busy_o) finished = 1;

      start_i = junk && !finished;
      if (start_i) begin
        col_i = COL_W'($urandom_range(0, 3));
        nbits_i = '0;
      end
      abort_i = !finished && (abort_at >= 0) && !aborted && (nshift == abort_at + 1);
      if (abort_i) aborted = 1;
      if (word_ready_o && idx >= 1 && gap_left > 0) begin
        word_valid_i = 1'b0;
        gap_left--;
      end else if (idx < nwords) begin
        word_valid_i = 1'b1;
        word_data_i = words[idx];
      end else begin
        word_valid_i = 1'($urandom_range(0, 1));
        word_data_i = $urandom;
        if (word_ready_o && !finished) bad_ready++;
      end
      if (word_valid_i && word_ready_o && !abort_i) idx++;
    end
    start_i = 1'b0; abort_i = 1'b0; word_valid_i = 1'b0;

    exp_shift = (abort_at >= 0) ? abort_at + 1 : nbits;
    exp_set   = (abort_at >= 0) ? 0 : 1;
    exp_stall = (abort_at < 0 && nwords > 1) ? gap : 0;
    vectors++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: busy never dropped", name);
    end
    vectors++;
    if (nshift != exp_shift) begin
      errors++;
      $display("FAIL %s shift_count: got %0d want %0d", name, nshift, exp_shift);
    end
    vectors++;
    if (nset != exp_set || ndone != exp_set) begin
      errors++;
      $display("FAIL %s set_done_count: set=%0d done=%0d want %0d", name, nset, ndone, exp_set);
    end
    vectors++;
    if (first_shift != 2) begin
      errors++;
      $display("FAIL %s latency: first shift at cycle %0d want 2", name, first_shift);
    end
    vectors++;
    if (stalls != exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stall);
    end
    vectors++;
    if (errs_seen != 0 || bad_ready != 0) begin
      errors++;
      $display("FAIL %s spurious: err pulses=%0d extra ready=%0d want 0/0", name, errs_seen, bad_ready);
    end
    vectors++;
    if (word_ready_o !== 1'b0 || busy_o !== 1'b0 || cen_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: ready=%b busy=%b cen=%b want 0", name, word_ready_o, busy_o, cen_o);
    end
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int k = 0; k < n; k++) words.push_back(WORD_W'($urandom));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge wb_clk_i);
    vectors++;
    if ({cfg_bit_o, shift_o, set_o, cen_o, busy_o, done_o, err_o, word_ready_o} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs %b want all 0",
               {cfg_bit_o, shift_o, set_o, cen_o, busy_o, done_o, err_o, word_ready_o});
    end
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    vectors++;
    if (busy_o !== 1'b0 || word_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b ready=%b want 0", busy_o, word_ready_o);
    end
  endtask

  task automatic test_errors();
    int bad_nb[2];
    bad_nb[0] = 0;
    bad_nb[1] = CHAIN_BITS + 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge wb_clk_i);
      start_i = 1'b1; col_i = 2'd1; nbits_i = NB_W'(bad_nb[i]);
      @(negedge wb_clk_i);
      start_i = 1'b0;
      vectors++;
      if (err_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL err_nbits_%0d: err=%b busy=%b want 1/0", bad_nb[i], err_o, busy_o);
      end
      @(negedge wb_clk_i);
      vectors++;
      if (err_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse_%0d: err=%b busy=%b want 0/0", bad_nb[i], err_o, busy_o);
      end
    end
    @(negedge wb_clk_i);
    start3 = 1'b1; col3 = 2'd3; nbits_i = NB_W'(8);
    @(negedge wb_clk_i);
    start3 = 1'b0;
    vectors++;
    if (err3 !== 1'b1 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL err_col: err=%b busy=%b want 1/0", err3, busy3);
    end
    @(negedge wb_clk_i);
    vectors++;
    if (err3 !== 1'b0 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL err_col_pulse: err=%b busy=%b want 0/0", err3, busy3);
    end
  endtask

  task automatic test_two_words();
    words = '{32'hA5A5_0F0F, 32'h1234_5678};
    run_load(1, 64, 0, -1, 1'b1, "two_words");
  endtask

  task automatic test_partial_word();
    words = '{32'hFFFF_FFFF, 32'h0000_00AB};
    run_load(2, 40, 0, -1, 1'b0, "partial_word");
  endtask

  task automatic test_stall();
    fill_random(2);
    run_load(3, 64, 5, -1, 1'b0, "stall");
  endtask

  task automatic test_abort();
    fill_random(2);
    run_load(0, 64, 0, 10, 1'b0, "abort");
    fill_random(2);
    run_load(0, 64, 0, -1, 1'b0, "after_abort");
  endtask

  task automatic test_reset_mid_shift();
    @(negedge wb_clk_i);
    start_i = 1'b1; col_i = 2'd2; nbits_i = NB_W'(64);
    word_valid_i = 1'b1; word_data_i = 32'hFFFF_FFFF;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    repeat (12) @(negedge wb_clk_i);
    vectors++;
    if (busy_o !== 1'b1 || shift_o !== 4'b0100) begin
      errors++;
      $display("FAIL pre_reset: busy=%b shift=%b want 1/0100", busy_o, shift_o);
    end
    #2 wb_rst_i = 1'b0;
    #1;
    vectors++;
    if ({cfg_bit_o, shift_o, set_o, cen_o, busy_o, done_o, err_o, word_ready_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: outputs %b want all 0",
               {cfg_bit_o, shift_o, set_o, cen_o, busy_o, done_o, err_o, word_ready_o});
    end
    @(negedge wb_clk_i);
    vectors++;
    if (set_o !== '0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: set=%b done=%b busy=%b want 0", set_o, done_o, busy_o);
    end
    word_valid_i = 1'b0;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    vectors++;
    if (busy_o !== 1'b0 || set_o !== '0) begin
      errors++;
      $display("FAIL post_reset: busy=%b set=%b want 0", busy_o, set_o);
    end
    fill_random(1);
    run_load(2, 20, 0, -1, 1'b0, "after_reset");
  endtask

  task automatic test_boundaries();
    fill_random(1);
    run_load(0, 1, 0, -1, 1'b0, "nbits_1");
    fill_random(1);
    run_load(3, WORD_W, 0, -1, 1'b0, "nbits_word");
    fill_random(CHAIN_BITS / WORD_W);
    run_load(1, CHAIN_BITS, 0, -1, 1'b0, "nbits_max");
  endtask

  task automatic test_random();
    int nb;
    for (int t = 0; t < 10; t++) begin
      nb = $urandom_range(1, 200);
      fill_random((nb + WORD_W - 1) / WORD_W);
      run_load($urandom_range(0, NUM_COLS - 1), nb, $urandom_range(0, 4), -1,
               1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    wb_rst_i = 1'b0; start_i = 1'b0; col_i = '0; nbits_i = '0;
    word_valid_i = 1'b0; word_data_i = '0; abort_i = 1'b0;
    start3 = 1'b0; abort3 = 1'b0; col3 = '0;
    test_reset();
    test_errors();
    test_two_words();
    test_partial_word();
    test_stall();
    test_abort();
    test_reset_mid_shift();
    test_boundaries();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
